// File: rtl/cache_pkg.sv
// Shared FSM state encoding and access-size codes for the L1 parameter cache.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFill0  = 3'd1,
    StFill1  = 3'd2,
    StWrite  = 3'd3,
    StBypass = 3'd4,
    StDone   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SzWord = 2'd0,
    SzByte = 2'd1,
    SzHalf = 2'd2
  } size_e;

  // Byte wins over half when both strobes are set; neither set means word.
  function automatic size_e size_decode(input logic is_byte, input logic is_half);
    if (is_byte) return SzByte;
    if (is_half) return SzHalf;
    return SzWord;
  endfunction

  // Lane mask of an access placed at byte offset 0.
  function automatic logic [3:0] size_mask(input size_e sz);
    logic [3:0] m;
    unique case (sz)
      SzByte:  m = 4'b0001;
      SzHalf:  m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cache_load_align.sv
// Load data extraction: picks the addressed bytes out of a little-endian 64-bit
// window {word(A+4), word(A)} and sign- or zero-extends them.
module cache_load_align
  import cache_pkg::*;
(
  input  logic [63:0] window_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  assign shifted = 32'(window_i >> {offset_i, 3'b000});

  // Extend the selected byte/half; word passes through.
  always_comb begin
    data_o = shifted;
    if (size_i == SzByte) begin
      data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
    end else if (size_i == SzHalf) begin
      data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/param_cache_l1.sv
// Direct-mapped, word-per-line, write-through L1 cache with uncached bypass
// window, split (line-crossing) load support and hit/miss statistics.
module param_cache_l1
  import cache_pkg::*;
#(
  parameter int unsigned LINES        = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned UNCACHED_BIT = 31,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   readEnable,
  input  logic                   writeEnable,
  input  logic                   byteRead,
  input  logic                   halfRead,
  input  logic                   unsignedRead,
  input  logic                   byteWrite,
  input  logic                   halfWrite,
  input  logic [31:0]            dataIn,
  output logic [31:0]            dataOut,
  input  logic                   flush,
  output logic                   cacheReady,
  output logic [COUNT_WIDTH-1:0] hitCount,
  output logic [COUNT_WIDTH-1:0] missCount,
  output logic [ADDR_WIDTH-1:0]  memoryAddress,
  output logic [31:0]            memoryDataOut,
  output logic                   memoryReadEnable,
  output logic                   memoryWriteEnable,
  output logic [3:0]             memoryByteEnable,
  input  logic [31:0]            memoryDataIn,
  input  logic                   memoryReady
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDR_WIDTH - 2 - IdxW;

  // Storage: data/tag arrays are not reset, only the valid bits are.
  logic [31:0]      data_q [LINES];
  logic [TagW-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  // Control / datapath registers.
  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [31:0]            mem_wdata_q;
  logic [3:0]             mem_be_q;
  logic                   mem_re_q;
  logic                   mem_we_q;
  logic                   byp_q;
  logic                   byp_second_q;
  logic [31:0]            buf0_q;
  logic [31:0]            buf1_q;
  logic [COUNT_WIDTH-1:0] hit_cnt_q;
  logic [COUNT_WIDTH-1:0] miss_cnt_q;

  // Request decode.
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [IdxW-1:0]       idx0, idx1, fill_idx;
  logic [TagW-1:0]       tag0, tag1, fill_tag;
  size_e                 rd_size, wr_size;
  logic                  split, uncached, hit0, hit1, read_hit, req, addr_same;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;

  assign addr0    = {address[ADDR_WIDTH-1:2], 2'b00};
  assign addr1    = addr0 + ADDR_WIDTH'(4);
  assign idx0     = addr0[IdxW+1:2];
  assign idx1     = addr1[IdxW+1:2];
  assign tag0     = addr0[ADDR_WIDTH-1:IdxW+2];
  assign tag1     = addr1[ADDR_WIDTH-1:IdxW+2];
  assign fill_idx = mem_addr_q[IdxW+1:2];
  assign fill_tag = mem_addr_q[ADDR_WIDTH-1:IdxW+2];

  assign rd_size  = size_decode(byteRead, halfRead);
  assign wr_size  = size_decode(byteWrite, halfWrite);
  assign split    = ((rd_size == SzWord) && (address[1:0] != 2'b00)) ||
                    ((rd_size == SzHalf) && (address[1:0] == 2'b11));
  assign uncached = address[UNCACHED_BIT];
  assign hit0     = valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1     = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign read_hit = !uncached && hit0 && (!split || hit1);
  assign req      = readEnable || writeEnable;
  assign addr_same = (address == addr_q);

  // Out-of-word lanes fall off the top of the 4-bit mask and are dropped.
  assign wr_be    = size_mask(wr_size) << address[1:0];
  assign wr_data  = dataIn << {address[1:0], 3'b000};

  // Array update strobes; an aborted or flushed transfer never writes.
  logic fill_en, wr_done, wr_update, wr_inval;
  assign fill_en   = ((state_q == StFill0) || (state_q == StFill1)) && memoryReady &&
                     req && addr_same && !flush;
  assign wr_done   = (state_q == StWrite) && memoryReady && req && addr_same && !flush;
  assign wr_update = wr_done && (wr_size == SzWord) && (address[1:0] == 2'b00) && hit0;
  assign wr_inval  = wr_done && hit0 && !wr_update;

  // Data and tag arrays: refill on memory return, write-through update on aligned hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_idx] <= memoryDataIn;
      tag_q[fill_idx]  <= fill_tag;
    end else if (wr_update) begin
      data_q[idx0] <= dataIn;
    end
  end

  // Valid bits: flush wins over a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end else if (wr_inval) begin
      valid_q[idx0] <= 1'b0;
    end
  end

  // Main FSM with registered memory-side outputs and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      byp_q        <= 1'b0;
      byp_second_q <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else if (flush || ((state_q != StIdle) && (!req || !addr_same))) begin
      // Flush, request withdrawal or address change all abandon the transaction.
      state_q  <= StIdle;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (readEnable) begin
            addr_q       <= address;
            byp_q        <= 1'b0;
            byp_second_q <= 1'b0;
            if (uncached) begin
              state_q    <= StBypass;
              byp_q      <= 1'b1;
              mem_addr_q <= addr0;
              mem_re_q   <= 1'b1;
              mem_be_q   <= 4'hF;
            end else if (read_hit) begin
              state_q   <= StDone;
              hit_cnt_q <= hit_cnt_q + COUNT_WIDTH'(1);
            end else begin
              state_q    <= StFill0;
              miss_cnt_q <= miss_cnt_q + COUNT_WIDTH'(1);
              mem_addr_q <= hit0 ? addr1 : addr0;
              mem_re_q   <= 1'b1;
              mem_be_q   <= 4'hF;
            end
          end else if (writeEnable) begin
            addr_q      <= address;
            byp_q       <= 1'b0;
            state_q     <= StWrite;
            mem_addr_q  <= addr0;
            mem_wdata_q <= wr_data;
            mem_be_q    <= wr_be;
            mem_we_q    <= 1'b1;
          end
        end
        StFill0: begin
          if (memoryReady) begin
            // Second fill only when the first one was the low word and A+4 also misses.
            if ((mem_addr_q == addr0) && split && !hit1) begin
              state_q    <= StFill1;
              mem_addr_q <= addr1;
            end else begin
              state_q  <= StDone;
              mem_re_q <= 1'b0;
              mem_be_q <= '0;
            end
          end
        end
        StFill1: begin
          if (memoryReady) begin
            state_q  <= StDone;
            mem_re_q <= 1'b0;
            mem_be_q <= '0;
          end
        end
        StBypass: begin
          if (memoryReady) begin
            if (!byp_second_q) begin
              buf0_q <= memoryDataIn;
              if (split) begin
                byp_second_q <= 1'b1;
                mem_addr_q   <= addr1;
              end else begin
                state_q  <= StDone;
                mem_re_q <= 1'b0;
                mem_be_q <= '0;
              end
            end else begin
              buf1_q   <= memoryDataIn;
              state_q  <= StDone;
              mem_re_q <= 1'b0;
              mem_be_q <= '0;
            end
          end
        end
        StWrite: begin
          if (memoryReady) begin
            state_q  <= StDone;
            mem_we_q <= 1'b0;
            mem_be_q <= '0;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready: idle bus, a same-cycle hit, or a finished request still being held.
  always_comb begin
    cacheReady = 1'b0;
    if (!req) begin
      cacheReady = 1'b1;
    end else if (state_q == StIdle) begin
      cacheReady = readEnable && read_hit && !flush;
    end else if (state_q == StDone) begin
      cacheReady = addr_same;
    end
  end

  logic [63:0] window;
  assign window = ((state_q == StDone) && byp_q) ? {buf1_q, buf0_q} :
                                                   {data_q[idx1], data_q[idx0]};

  cache_load_align u_load_align (
    .window_i   (window),
    .offset_i   (address[1:0]),
    .size_i     (rd_size),
    .unsigned_i (unsignedRead),
    .data_o     (dataOut)
  );

  assign hitCount          = hit_cnt_q;
  assign missCount         = miss_cnt_q;
  assign memoryAddress     = mem_addr_q;
  assign memoryDataOut     = mem_wdata_q;
  assign memoryReadEnable  = mem_re_q;
  assign memoryWriteEnable = mem_we_q;
  assign memoryByteEnable  = mem_be_q;

endmodule

// File: tb/tb_param_cache_l1.sv
// Directed bench for param_cache_l1 with a fixed-latency memory responder.
module tb_param_cache_l1;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address;
  logic        readEnable, writeEnable, byteRead, halfRead, unsignedRead;
  logic        byteWrite, halfWrite, flush;
  logic [31:0] dataIn, dataOut;
  logic        cacheReady;
  logic [31:0] hitCount, missCount;
  logic [31:0] memoryAddress, memoryDataOut;
  logic        memoryReadEnable, memoryWriteEnable;
  logic [3:0]  memoryByteEnable;
  logic [31:0] memoryDataIn = '0;
  logic        memoryReady;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_cache_l1 #(
    .LINES        (32),
    .ADDR_WIDTH   (32),
    .UNCACHED_BIT (31),
    .COUNT_WIDTH  (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .address           (address),
    .readEnable        (readEnable),
    .writeEnable       (writeEnable),
    .byteRead          (byteRead),
    .halfRead          (halfRead),
    .unsignedRead      (unsignedRead),
    .byteWrite         (byteWrite),
    .halfWrite         (halfWrite),
    .dataIn            (dataIn),
    .dataOut           (dataOut),
    .flush             (flush),
    .cacheReady        (cacheReady),
    .hitCount          (hitCount),
    .missCount         (missCount),
    .memoryAddress     (memoryAddress),
    .memoryDataOut     (memoryDataOut),
    .memoryReadEnable  (memoryReadEnable),
    .memoryWriteEnable (memoryWriteEnable),
    .memoryByteEnable  (memoryByteEnable),
    .memoryDataIn      (memoryDataIn),
    .memoryReady       (memoryReady)
  );

  // Backing memory: 256 words indexed by address[9:2]; written only by the stimulus.
  logic [31:0] mem [256];
  int          rd_count = 0;
  int          cnt;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0;

  // Responds LAT cycles after an enable is seen, one-cycle ready pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memoryReady <= 1'b0;
      cnt         <= 0;
    end else if (memoryReady) begin
      memoryReady <= 1'b0;
      cnt         <= 0;
    end else if (memoryReadEnable || memoryWriteEnable) begin
      if (cnt == LAT - 1) begin
        memoryReady <= 1'b1;
        cnt         <= 0;
        if (memoryReadEnable) begin
          memoryDataIn <= mem[memoryAddress[9:2]];
          rd_count     <= rd_count + 1;
        end else begin
          last_be    <= memoryByteEnable;
          last_wdata <= memoryDataOut;
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a read, wait for cacheReady (bounded), return data and cycles waited.
  task automatic rd(input logic [31:0] a, input logic b, input logic h, input logic u,
                    output logic [31:0] d, output int lat);
    address = a; byteRead = b; halfRead = h; unsignedRead = u; readEnable = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!cacheReady && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_ready", {63'b0, cacheReady}, 64'd1);
    d = dataOut;
    @(posedge clk); #1;
    readEnable = 1'b0; byteRead = 1'b0; halfRead = 1'b0; unsignedRead = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic b, input logic h, input logic [31:0] v);
    int n;
    address = a; byteWrite = b; halfWrite = h; dataIn = v; writeEnable = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cacheReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready", {63'b0, cacheReady}, 64'd1);
    @(posedge clk); #1;
    writeEnable = 1'b0; byteWrite = 1'b0; halfWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  logic [31:0] d;
  int          lat;
  int          r0;
  int          n;

  initial begin
    address = '0; readEnable = 0; writeEnable = 0; byteRead = 0; halfRead = 0;
    unsignedRead = 0; byteWrite = 0; halfWrite = 0; dataIn = '0; flush = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_re", {63'b0, memoryReadEnable}, 64'd0);
    chk("rst_we", {63'b0, memoryWriteEnable}, 64'd0);
    chk("rst_be", {60'b0, memoryByteEnable}, 64'd0);
    chk("rst_hit", {32'b0, hitCount}, 64'd0);
    chk("rst_miss", {32'b0, missCount}, 64'd0);
    chk("rst_ready", {63'b0, cacheReady}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Miss then same-cycle hit on 0x100.
    mem[8'h40] = 32'hDEADBEEF;
    rd(32'h100, 0, 0, 0, d, lat);
    chk("miss_data", {32'b0, d}, 64'hDEADBEEF);
    chk("miss_lat", lat, 5);
    chk("miss_cnt1", {32'b0, missCount}, 64'd1);
    chk("miss_hit0", {32'b0, hitCount}, 64'd0);
    r0 = rd_count;
    rd(32'h100, 0, 0, 0, d, lat);
    chk("hit_data", {32'b0, d}, 64'hDEADBEEF);
    chk("hit_lat", lat, 0);
    chk("hit_cnt1", {32'b0, hitCount}, 64'd1);
    chk("hit_nomem", rd_count - r0, 0);

    // Split word read at 0x102 needs two fills.
    do_flush();
    mem[8'h40] = 32'h11223344;
    mem[8'h41] = 32'h55667788;
    r0 = rd_count;
    rd(32'h102, 0, 0, 0, d, lat);
    chk("split_data", {32'b0, d}, 64'h77881122);
    chk("split_reads", rd_count - r0, 2);
    chk("split_miss", {32'b0, missCount}, 64'd2);
    rd(32'h102, 0, 0, 0, d, lat);
    chk("split_hit_lat", lat, 0);
    chk("split_hit_data", {32'b0, d}, 64'h77881122);

    // Aligned word write updates the cached line; sub-word extraction.
    wr(32'h100, 0, 0, 32'h80FF0000);
    mem[8'h40] = 32'h80FF0000;
    chk("wr_be_word", {60'b0, last_be}, 64'hF);
    rd(32'h103, 1, 0, 0, d, lat);
    chk("byte_signed", {32'b0, d}, 64'hFFFFFF80);
    chk("byte_signed_lat", lat, 0);
    rd(32'h103, 1, 0, 1, d, lat);
    chk("byte_unsigned", {32'b0, d}, 64'h00000080);
    rd(32'h102, 0, 1, 0, d, lat);
    chk("half_signed", {32'b0, d}, 64'hFFFF80FF);
    rd(32'h103, 0, 1, 0, d, lat);
    chk("half_split", {32'b0, d}, 64'hFFFF8880);
    chk("hit_cnt6", {32'b0, hitCount}, 64'd6);

    // Write-through update, then invalidating byte and misaligned writes.
    wr(32'h100, 0, 0, 32'hCAFEF00D);
    mem[8'h40] = 32'hCAFEF00D;
    chk("wr2_be", {60'b0, last_be}, 64'hF);
    rd(32'h100, 0, 0, 0, d, lat);
    chk("wr_upd_lat", lat, 0);
    chk("wr_upd_data", {32'b0, d}, 64'hCAFEF00D);
    wr(32'h101, 1, 0, 32'h000000A5);
    mem[8'h40] = 32'hCAFEA50D;
    chk("bwr_be", {60'b0, last_be}, 64'h2);
    chk("bwr_data", {32'b0, last_wdata}, 64'h0000A500);
    rd(32'h100, 0, 0, 0, d, lat);
    chk("inval_miss_lat", lat, 5);
    chk("inval_data", {32'b0, d}, 64'hCAFEA50D);
    wr(32'h102, 0, 0, 32'h12345678);
    mem[8'h40] = 32'h5678A50D;
    chk("mis_be", {60'b0, last_be}, 64'hC);
    chk("mis_data", {32'b0, last_wdata}, 64'h56780000);
    rd(32'h100, 0, 0, 0, d, lat);
    chk("mis_inval_lat", lat, 5);
    chk("mis_inval_data", {32'b0, d}, 64'h5678A50D);
    chk("miss_cnt4", {32'b0, missCount}, 64'd4);
    chk("hit_cnt7", {32'b0, hitCount}, 64'd7);

    // Conflict on index 0, then uncached reads.
    mem[8'h60] = 32'h0F0F0F0F;
    rd(32'h180, 0, 0, 0, d, lat);
    chk("conf_data", {32'b0, d}, 64'h0F0F0F0F);
    rd(32'h100, 0, 0, 0, d, lat);
    chk("conf_relat", lat, 5);
    chk("miss_cnt6", {32'b0, missCount}, 64'd6);
    mem[8'h00] = 32'h0BADF00D;
    mem[8'h01] = 32'h13579BDF;
    r0 = rd_count;
    rd(32'h80000000, 0, 0, 0, d, lat);
    chk("byp_data", {32'b0, d}, 64'h0BADF00D);
    chk("byp_reads", rd_count - r0, 1);
    r0 = rd_count;
    rd(32'h80000002, 0, 0, 0, d, lat);
    chk("byp_split", {32'b0, d}, 64'h9BDF0BAD);
    chk("byp_split_reads", rd_count - r0, 2);
    chk("byp_hit", {32'b0, hitCount}, 64'd7);
    chk("byp_miss", {32'b0, missCount}, 64'd6);

    // Reset asserted during FILL0.
    address = 32'h1C0; readEnable = 1'b1;
    n = 0;
    while (!memoryReadEnable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill0_entered", {63'b0, memoryReadEnable}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstfill_re", {63'b0, memoryReadEnable}, 64'd0);
    chk("rstfill_miss", {32'b0, missCount}, 64'd0);
    readEnable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstfill_ready", {63'b0, cacheReady}, 64'd1);
    rd(32'h100, 0, 0, 0, d, lat);
    chk("rst_valid_clr", lat, 5);

    // Flush after fills: next read misses again.
    rd(32'h100, 0, 0, 0, d, lat);
    chk("pre_flush_hit", lat, 0);
    do_flush();
    rd(32'h100, 0, 0, 0, d, lat);
    chk("post_flush_lat", lat, 5);
    chk("post_flush_miss", {32'b0, missCount}, 64'd2);
    chk("post_flush_hit", {32'b0, hitCount}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
